// File: rtl/gate_exerciser.sv
// gate_exerciser: steps a 2-input gate block through its 4 input vectors.
// Optional comparator enabled by defining GATE_EXERCISER_SELFCHECK_EN.
module gate_exerciser #(
  parameter int DEB_CYC    = 16,
  parameter int TICK_DIV   = 100000000,
  parameter int SETTLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_btn,
  input  logic       auto_en,
  input  logic [7:0] y_in,
  output logic       a,
  output logic       b,
  output logic [1:0] vec_idx,
  output logic [7:0] y_cap,
  output logic       pass,
  output logic       fail,
  output logic [7:0] fail_cnt
);
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] CHECK   = 2'd2;
  localparam logic [1:0] ADVANCE = 2'd3;

  logic          s1;
  logic          s2;
  logic          deb_lvl;
  logic          deb_q;
  logic [DW-1:0] deb_cnt;
  logic [TW-1:0] pre_cnt;
  logic [SW-1:0] set_cnt;
  logic [1:0]    state;
  logic [1:0]    vec_nxt;
  logic          tick;
  logic          btn_evt;
  logic          evt;

  assign btn_evt = deb_lvl & ~deb_q;
  assign tick    = auto_en && (pre_cnt == TW'(TICK_DIV - 1));
  assign evt     = btn_evt | tick;
  assign vec_nxt = vec_idx + 2'd1;

  // two-flop synchronizer for the raw button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= step_btn;
      s2 <= s1;
    end
  end

  // debounce: take the new level once it has differed for DEB_CYC cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt <= '0;
      deb_lvl <= 1'b0;
      deb_q   <= 1'b0;
    end else begin
      deb_q <= deb_lvl;
      if (s2 == deb_lvl) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEB_CYC - 1)) begin
        deb_lvl <= s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  // auto-step prescaler, parked at 0 while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (!auto_en || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + TW'(1);
    end
  end

  // step sequencer: settle, capture, check, advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      set_cnt <= '0;
      y_cap   <= 8'h00;
      vec_idx <= 2'd0;
      a       <= 1'b0;
      b       <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (evt) begin
            state   <= SETTLE;
            set_cnt <= SW'(SETTLE_CYC - 1);
          end
        end
        (state == SETTLE): begin
          if (set_cnt == '0) begin
            y_cap <= y_in;
            state <= CHECK;
          end else begin
            set_cnt <= set_cnt - SW'(1);
          end
        end
        (state == CHECK): begin
          state <= ADVANCE;
        end
        default: begin
          vec_idx <= vec_nxt;
          a       <= vec_nxt[1];
          b       <= vec_nxt[0];
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef GATE_EXERCISER_SELFCHECK_EN
  logic [7:0] exp_y;

  // expected gate outputs for the vector currently applied
  always_comb begin
    exp_y = 8'hEC;
    unique case (1'b1)
      (vec_idx == 2'd0): exp_y = 8'hEC;
      (vec_idx == 2'd1): exp_y = 8'h56;
      (vec_idx == 2'd2): exp_y = 8'h96;
      default:           exp_y = 8'h23;
    endcase
  end

  // comparator and saturating mismatch counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass     <= 1'b0;
      fail     <= 1'b0;
      fail_cnt <= 8'h00;
    end else if (state == CHECK) begin
      pass <= (y_cap == exp_y);
      fail <= (y_cap != exp_y);
      if ((y_cap != exp_y) && (fail_cnt != 8'hFF)) begin
        fail_cnt <= fail_cnt + 8'd1;
      end
    end
  end
`else
  assign pass     = 1'b0;
  assign fail     = 1'b0;
  assign fail_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_gate_exerciser.sv
// tb_gate_exerciser: randomized bench with a truth-table reference model.
// Expectations for pass/fail/fail_cnt follow GATE_EXERCISER_SELFCHECK_EN.
module tb_gate_exerciser;
  localparam int DEB  = 4;
  localparam int SET  = 2;
  localparam int TDIV = 8;
`ifdef GATE_EXERCISER_SELFCHECK_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       step_btn = 1'b0;
  logic       auto_en = 1'b0;
  logic [7:0] y_in;
  logic       a;
  logic       b;
  logic [1:0] vec_idx;
  logic [7:0] y_cap;
  logic       pass;
  logic       fail;
  logic [7:0] fail_cnt;

  logic [7:0] and_mask = 8'hFF;
  logic [7:0] xor_mask = 8'h00;
  logic       zero_mode = 1'b0;

  int checks = 0;
  int failures = 0;

  int         m_vec;
  logic [7:0] m_ycap;
  logic       m_pass;
  logic       m_fail;
  int         m_cnt;

  gate_exerciser #(
    .DEB_CYC(DEB),
    .TICK_DIV(TDIV),
    .SETTLE_CYC(SET)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .step_btn(step_btn),
    .auto_en(auto_en),
    .y_in(y_in),
    .a(a),
    .b(b),
    .vec_idx(vec_idx),
    .y_cap(y_cap),
    .pass(pass),
    .fail(fail),
    .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gate_fn(input logic ai, input logic bi);
    return {~bi, ~ai, ~(ai ^ bi), ai ^ bi,
            ~(ai | bi), ~(ai & bi), ai | bi, ai & bi};
  endfunction

  assign y_in = zero_mode ? 8'h00 : ((gate_fn(a, b) & and_mask) ^ xor_mask);

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  task automatic m_reset();
    m_vec  = 0;
    m_ycap = 8'h00;
    m_pass = 1'b0;
    m_fail = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic m_capture();
    logic [1:0] mv;
    mv = 2'(m_vec);
    m_ycap = zero_mode ? 8'h00
           : ((gate_fn(mv[1], mv[0]) & and_mask) ^ xor_mask);
  endtask

  task automatic m_check();
    logic [1:0] mv;
    logic ok;
    mv = 2'(m_vec);
    ok = (m_ycap == gate_fn(mv[1], mv[0]));
    if (SC) begin
      m_pass = ok;
      m_fail = !ok;
      if (!ok && m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic m_advance();
    m_vec = (m_vec + 1) % 4;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [1:0] mv;
    mv = 2'(m_vec);
    check({tag, ".y_cap"}, 32'(y_cap), 32'(m_ycap));
    check({tag, ".vec"}, 32'(vec_idx), 32'(mv));
    check({tag, ".a"}, 32'(a), 32'(mv[1]));
    check({tag, ".b"}, 32'(b), 32'(mv[0]));
    check({tag, ".pass"}, 32'(pass), 32'(m_pass));
    check({tag, ".fail"}, 32'(fail), 32'(m_fail));
    check({tag, ".cnt"}, 32'(fail_cnt), 32'(m_cnt));
  endtask

  task automatic press();
    step_btn = 1'b1;
    cyc(10);
    step_btn = 1'b0;
    cyc(12);
    m_capture();
    m_check();
    m_advance();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int ticks;
    m_reset();
    cyc(3);
    check_all("reset");
    rst_n = 1'b1;
    cyc(2);

    for (int i = 0; i < 4; i++) begin
      press();
      check_all("clean");
    end
    check("clean_wrap", 32'(vec_idx), 32'd0);

    and_mask = 8'hEF;
    for (int i = 0; i < 4; i++) begin
      press();
      check_all("stuck");
    end
    check("stuck_cnt", 32'(fail_cnt), SC ? 32'd2 : 32'd0);
    and_mask = 8'hFF;

    for (int i = 0; i < 10; i++) begin
      step_btn = ~step_btn;
      cyc(2);
    end
    check("bounce_quiet", 32'(vec_idx), 32'(m_vec));
    step_btn = 1'b1;
    cyc(14);
    m_capture();
    m_check();
    m_advance();
    check_all("bounce");
    step_btn = 1'b0;
    cyc(12);
    check_all("bounce_rel");

    for (int i = 0; i < 12; i++) begin
      xor_mask = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      cyc($urandom_range(0, 5));
      press();
      check_all("rand");
    end
    xor_mask = 8'h00;

    auto_en = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      cyc(1);
      if (k == 1 || k == 18) step_btn = 1'b1;
      if (k == 9 || k == 26) step_btn = 1'b0;
      if (k == 40) auto_en = 1'b0;
      if (k >= 10 && k <= 42 && (k % 8) == 2) m_capture();
      if (k >= 11 && k <= 43 && (k % 8) == 3) m_check();
      if (k >= 12 && k <= 44 && (k % 8) == 4) m_advance();
      check("auto.vec", 32'(vec_idx), 32'(m_vec));
      check("auto.ycap", 32'(y_cap), 32'(m_ycap));
      check("auto.pass", 32'(pass), 32'(m_pass));
    end

    zero_mode = 1'b1;
    auto_en = 1'b1;
    ticks = 0;
    for (int k = 1; k <= 2410; k++) begin
      cyc(1);
      if ((k % 8) == 7) ticks++;
    end
    auto_en = 1'b0;
    cyc(20);
    for (int i = 0; i < ticks; i++) begin
      m_capture();
      m_check();
      m_advance();
    end
    check_all("sat");
    check("sat_cnt", 32'(fail_cnt), SC ? 32'd255 : 32'd0);
    zero_mode = 1'b0;

    step_btn = 1'b1;
    cyc(7);
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all("rst_mid");
    step_btn = 1'b0;
    cyc(2);
    check_all("rst_hold");
    rst_n = 1'b1;
    cyc(12);
    check_all("rst_idle");
    press();
    check_all("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
